// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the data-cache responder.
//   - state_e   : responder FSM encoding
//   - WORD_MASK : clears the byte offset of a byte address
//   - dc_idx_w / dc_tag_w : index and tag widths derived from the line count
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  // Index width: one-word lines, so the index sits directly above the byte offset.
  function automatic int dc_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: whatever remains of the 30-bit word address above the index.
  function automatic int dc_tag_w(input int lines);
    return 30 - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage for a direct-mapped cache of one-word lines.
// Ports:
//   clk          clock
//   clr_i        synchronous clear of every valid bit (tags/data untouched)
//   we_i         write enable for data and tag at widx_i
//   set_valid_i  also mark the written line valid (line fills)
//   widx_i/wtag_i/wdata_i  write port
//   ridx_i/rtag_i          combinational lookup
//   hit_o        line at ridx_i is valid and its tag equals rtag_i
//   rdata_o      data stored at ridx_i
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX   = dc_idx_w(LINES),
  parameter int TAG   = dc_tag_w(LINES)
) (
  input  logic           clk,
  input  logic           clr_i,
  input  logic           we_i,
  input  logic           set_valid_i,
  input  logic [IDX-1:0] widx_i,
  input  logic [TAG-1:0] wtag_i,
  input  logic [31:0]    wdata_i,
  input  logic [IDX-1:0] ridx_i,
  input  logic [TAG-1:0] rtag_i,
  output logic           hit_o,
  output logic [31:0]    rdata_o
);

  logic [LINES-1:0] valid_q;
  logic [TAG-1:0]   tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Valid bits: clear-all has priority over a fill in the same cycle.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= {LINES{1'b0}};
    end else if (we_i && set_valid_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  // Tag and data storage; a write during clear is dropped so nothing half-recorded survives.
  always_ff @(posedge clk) begin
    if (we_i && !clr_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign hit_o   = valid_q[ridx_i] && (tag_q[ridx_i] == rtag_i);
  assign rdata_o = data_q[ridx_i];

endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: memory-side responder for the core's M-stage data port.
// Direct-mapped, write-through, no-write-allocate cache of one-word lines in
// front of a fixed-latency backing memory.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   memwritem, wbsrcm, aluoutm, writedatam   M-stage request (wbsrcm[0] = load)
//   readdata, countdone             load data / 0 = core must stall
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata   backing memory port
//   hit_count, miss_count           load hit/miss counters
// Optional feature: define DCACHE_STATS_EN to build the hit/miss counters;
// otherwise both counter outputs are tied to zero.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int LINES       = 64,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwritem,
  input  logic [2:0]  wbsrcm,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  output logic [31:0] readdata,
  output logic        countdone,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX = dc_idx_w(LINES);
  localparam int TAG = dc_tag_w(LINES);

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [31:0] readdata_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic           load_s, store_s, idle_s, hit_s;
  logic [31:0]    line_data_s;
  logic [IDX-1:0] req_idx_s, fill_idx_s, w_idx_s;
  logic [TAG-1:0] req_tag_s, fill_tag_s, w_tag_s;
  logic           arr_we_s, arr_set_valid_s;
  logic [31:0]    arr_wdata_s;
  logic           unused_s;

  // A store wins when both request bits are set.
  assign store_s = memwritem;
  assign load_s  = wbsrcm[0] & ~memwritem;
  assign idle_s  = (state_q == ST_IDLE);

  assign req_idx_s = aluoutm[IDX+1:2];
  assign req_tag_s = aluoutm[31:IDX+2];
  // The fill uses the latched address so input wiggles during the miss are ignored.
  assign fill_idx_s = mem_addr_q[IDX+1:2];
  assign fill_tag_s = mem_addr_q[31:IDX+2];

  assign unused_s = ^{wbsrcm[2:1], aluoutm[1:0], mem_addr_q[1:0]};

  dcache_array #(.LINES(LINES)) u_array (
    .clk         (clk),
    .clr_i       (reset),
    .we_i        (arr_we_s),
    .set_valid_i (arr_set_valid_s),
    .widx_i      (w_idx_s),
    .wtag_i      (w_tag_s),
    .wdata_i     (arr_wdata_s),
    .ridx_i      (req_idx_s),
    .rtag_i      (req_tag_s),
    .hit_o       (hit_s),
    .rdata_o     (line_data_s)
  );

  // Array write select: store hit updates in place, last miss cycle fills the line.
  always_comb begin
    arr_we_s        = 1'b0;
    arr_set_valid_s = 1'b0;
    w_idx_s         = req_idx_s;
    w_tag_s         = req_tag_s;
    arr_wdata_s     = writedatam;
    if (idle_s && store_s && hit_s) begin
      arr_we_s = 1'b1;
    end else if ((state_q == ST_RD_MISS) && (cnt_q == 32'd0)) begin
      arr_we_s        = 1'b1;
      arr_set_valid_s = 1'b1;
      w_idx_s         = fill_idx_s;
      w_tag_s         = fill_tag_s;
      arr_wdata_s     = mem_rdata;
    end else begin
      arr_we_s = 1'b0;
    end
  end

  // Responder FSM with registered memory-side outputs and load data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 32'd0;
      readdata_q  <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (store_s) begin
            state_q     <= ST_WR_THRU;
            cnt_q       <= 32'(MEM_LATENCY - 1);
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= aluoutm & WORD_MASK;
            mem_wdata_q <= writedatam;
          end else if (load_s && !hit_s) begin
            state_q    <= ST_RD_MISS;
            cnt_q      <= 32'(MEM_LATENCY - 1);
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= aluoutm & WORD_MASK;
          end else if (load_s) begin
            // Keep the hit data so readdata holds it once the request goes away.
            readdata_q <= line_data_s;
          end
        end
        ST_RD_MISS: begin
          if (cnt_q == 32'd0) begin
            readdata_q <= mem_rdata;
            state_q    <= ST_DONE;
            mem_en_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        ST_WR_THRU: begin
          if (cnt_q == 32'd0) begin
            state_q  <= ST_DONE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        ST_DONE: begin
          // Requests are not sampled here; the core is only now advancing.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall decision: an IDLE miss or store stalls in its own cycle, DONE releases.
  always_comb begin
    countdone = 1'b1;
    if (reset) begin
      countdone = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: countdone = ~(store_s | (load_s & ~hit_s));
        ST_DONE: countdone = 1'b1;
        default: countdone = 1'b0;
      endcase
    end
  end

  // A hit is returned in the same cycle; otherwise the registered value is shown.
  assign readdata  = (!reset && idle_s && load_s && hit_s) ? line_data_s : readdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Load hit/miss statistics, counted only on IDLE lookups, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else if (idle_s && load_s) begin
      if (hit_s) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: self-checking bench for dcache_responder.
// A directed vector table, a reset-during-miss sequence and a randomized phase
// are checked against a transaction-level cache/memory model.
module tb_dcache_responder;

  localparam int LINES = 64;
  localparam int LAT   = 4;
  localparam int IDX   = $clog2(LINES);

  logic        clk = 1'b0;
  logic        reset;
  logic        memwritem;
  logic [2:0]  wbsrcm;
  logic [31:0] aluoutm;
  logic [31:0] writedatam;
  logic [31:0] readdata;
  logic        countdone;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  dcache_responder #(.LINES(LINES), .MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwritem  (memwritem),
    .wbsrcm     (wbsrcm),
    .aluoutm    (aluoutm),
    .writedatam (writedatam),
    .readdata   (readdata),
    .countdone  (countdone),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Backing memory contents; unwritten words return an address-derived pattern.
  logic [31:0] bmem [logic [31:0]];

  function automatic logic [31:0] memval(input logic [31:0] word);
    if (bmem.exists(word)) return bmem[word];
    return word ^ 32'hC0DE_0000;
  endfunction

  // Reference model: one cached word per index, plus last load value and stats.
  bit          mv [LINES];
  logic [31:0] mt [LINES];
  logic [31:0] md [LINES];
  logic [31:0] mrd;
  int          mhits, mmiss;

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    mrd = 32'd0; mhits = 0; mmiss = 0;
  endtask

  task automatic model_access(input logic mw, input logic [2:0] wb, input logic [31:0] addr,
                              input logic [31:0] wd, output bit stall, output logic [31:0] rd);
    int unsigned idx;
    logic [31:0] tag;
    idx = (addr >> 2) % LINES;
    tag = addr >> (IDX + 2);
    stall = 1'b0;
    if (mw) begin
      stall = 1'b1;
      if (mv[idx] && mt[idx] == tag) md[idx] = wd;
    end else if (wb[0]) begin
      if (mv[idx] && mt[idx] == tag) begin
        mrd = md[idx]; mhits++;
      end else begin
        stall = 1'b1;
        mrd = memval(addr & ~32'd3);
        mv[idx] = 1'b1; mt[idx] = tag; md[idx] = mrd; mmiss++;
      end
    end
    rd = mrd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Fixed-latency memory: data is valid only in the LAT-th cycle of mem_en.
  int en_cycles = 0;
  initial begin
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk); #2;
      if (mem_en === 1'b1) en_cycles++; else en_cycles = 0;
      if (mem_en === 1'b1 && en_cycles == LAT) begin
        mem_rdata = memval(mem_addr);
        if (mem_we === 1'b1) bmem[mem_addr] = mem_wdata;
      end else begin
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Present one request and follow it to completion, checking the memory port.
  task automatic run_access(input logic mw, input logic [2:0] wb, input logic [31:0] addr,
                            input logic [31:0] wd, input bit scramble,
                            output bit stalled, output logic [31:0] rd);
    int  stalls;
    bit  done;
    @(negedge clk);
    memwritem = mw; wbsrcm = wb; aluoutm = addr; writedatam = wd;
    #1;
    stalled = (countdone !== 1'b1);
    rd = readdata;
    if (stalled) begin
      stalls = 1; done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
        @(negedge clk);
        if (scramble) begin
          memwritem = 1'($urandom); wbsrcm = 3'($urandom);
          aluoutm = $urandom; writedatam = $urandom;
        end
        #1;
        if (countdone === 1'b1) begin
          done = 1'b1;
          rd = readdata;
          chk("done_mem_en", {31'd0, mem_en}, 32'd0);
          chk("done_mem_we", {31'd0, mem_we}, 32'd0);
        end else begin
          stalls++;
          chk("stall_mem_en", {31'd0, mem_en}, 32'd1);
          chk("stall_mem_we", {31'd0, mem_we}, {31'd0, mw});
          chk("stall_mem_addr", mem_addr, addr & ~32'd3);
          if (mw) chk("stall_mem_wdata", mem_wdata, wd);
        end
      end
      if (!done) chk("access_timeout", 32'd0, 32'd1);
      chk("stall_cycles", 32'(stalls), 32'(LAT + 1));
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    memwritem = 1'b0; wbsrcm = 3'd0; aluoutm = 32'd0; writedatam = 32'd0;
  endtask

  task automatic check_stats(input string nm);
`ifdef DCACHE_STATS_EN
    chk({nm, "_hits"}, hit_count, 32'(mhits));
    chk({nm, "_misses"}, miss_count, 32'(mmiss));
`else
    chk({nm, "_hits"}, hit_count, 32'd0);
    chk({nm, "_misses"}, miss_count, 32'd0);
`endif
  endtask

  typedef struct {
    logic        mw;
    logic [2:0]  wb;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          stall;
    logic [31:0] rd;
  } vec_t;

  vec_t        tbl [13];
  bit          o_stall, m_stall;
  logic [31:0] o_rd, m_rd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Index 0 for 0x100/0x200/0x300: all addresses below conflict on one line.
    tbl[0]  = '{1'b0, 3'b001, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[1]  = '{1'b0, 3'b001, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 3'b000, 32'h0000_0100, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b0, 3'b001, 32'h0000_0100, 32'h0,         1'b0, 32'h1234_5678};
    tbl[4]  = '{1'b0, 3'b001, 32'h0000_0200, 32'h0,         1'b1, 32'h2222_0200};
    tbl[5]  = '{1'b0, 3'b001, 32'h0000_0100, 32'h0,         1'b1, 32'h1234_5678};
    tbl[6]  = '{1'b1, 3'b000, 32'h0000_0300, 32'hABCD_0001, 1'b1, 32'h1234_5678};
    tbl[7]  = '{1'b0, 3'b001, 32'h0000_0300, 32'h0,         1'b1, 32'hABCD_0001};
    tbl[8]  = '{1'b1, 3'b011, 32'h0000_0302, 32'h0000_55AA, 1'b1, 32'hABCD_0001};
    tbl[9]  = '{1'b0, 3'b101, 32'h0000_0301, 32'h0,         1'b0, 32'h0000_55AA};
    tbl[10] = '{1'b0, 3'b110, 32'h0000_0200, 32'h0,         1'b0, 32'h0000_55AA};
    tbl[11] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         1'b1, 32'h1234_5678};
    tbl[12] = '{1'b0, 3'b001, 32'h0000_0100, 32'h0,         1'b0, 32'h1234_5678};

    bmem[32'h0000_0100] = 32'hDEAD_BEEF;
    bmem[32'h0000_0200] = 32'h2222_0200;
    model_reset();

    reset = 1'b1; memwritem = 1'b0; wbsrcm = 3'd0; aluoutm = 32'd0; writedatam = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_countdone", {31'd0, countdone}, 32'd1);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    check_stats("rst");

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      model_access(tbl[i].mw, tbl[i].wb, tbl[i].addr, tbl[i].wd, m_stall, m_rd);
      run_access(tbl[i].mw, tbl[i].wb, tbl[i].addr, tbl[i].wd, 1'b0, o_stall, o_rd);
      chk($sformatf("vec%0d_stall", i), {31'd0, o_stall}, {31'd0, tbl[i].stall});
      chk($sformatf("vec%0d_readdata", i), o_rd, tbl[i].rd);
      chk($sformatf("vec%0d_model_readdata", i), o_rd, m_rd);
    end
    idle_inputs(); #1;
    check_stats("table");

    // Reset while a miss is in flight with the counter at 2.
    @(negedge clk);
    memwritem = 1'b0; wbsrcm = 3'b001; aluoutm = 32'h0000_0604; writedatam = 32'd0;
    #1 chk("midrst_req_stall", {31'd0, countdone}, 32'd0);
    @(negedge clk); #1 chk("midrst_mem_en_busy", {31'd0, mem_en}, 32'd1);
    @(negedge clk);
    reset = 1'b1; memwritem = 1'b0; wbsrcm = 3'd0; aluoutm = 32'd0;
    @(posedge clk); #1 reset = 1'b0;
    #1;
    chk("midrst_countdone", {31'd0, countdone}, 32'd1);
    chk("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("midrst_readdata", readdata, 32'd0);
    model_reset();
    check_stats("midrst");
    model_access(1'b0, 3'b001, 32'h0000_0604, 32'd0, m_stall, m_rd);
    run_access(1'b0, 3'b001, 32'h0000_0604, 32'd0, 1'b0, o_stall, o_rd);
    chk("midrst_reload_miss", {31'd0, o_stall}, 32'd1);
    chk("midrst_reload_data", o_rd, m_rd);
    model_access(1'b0, 3'b001, 32'h0000_0300, 32'd0, m_stall, m_rd);
    run_access(1'b0, 3'b001, 32'h0000_0300, 32'd0, 1'b0, o_stall, o_rd);
    chk("midrst_cleared_miss", {31'd0, o_stall}, 32'd1);
    chk("midrst_cleared_data", o_rd, 32'h0000_55AA);

    // Randomized traffic over a few conflicting tags, inputs scrambled while stalled.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, w;
      logic        mw;
      logic [2:0]  wb;
      a  = (32'($urandom_range(1, 6)) << 8) | (32'($urandom_range(0, 3)) << 2)
           | 32'($urandom_range(0, 3));
      mw = ($urandom_range(0, 3) == 0);
      wb = 3'($urandom_range(0, 7));
      w  = $urandom;
      model_access(mw, wb, a, w, m_stall, m_rd);
      run_access(mw, wb, a, w, 1'b1, o_stall, o_rd);
      chk($sformatf("rnd%0d_stall", n), {31'd0, o_stall}, {31'd0, m_stall});
      chk($sformatf("rnd%0d_readdata", n), o_rd, m_rd);
    end
    idle_inputs(); #1;
    check_stats("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
